// File: rtl/qbert_poll_pkg.sv
// Shared types and helpers for the Q*bert button poller.
// Holds the poll FSM state encoding, the PIO data address and the counter-width helper.
package qbert_poll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    SAMPLE = 2'd3
  } poll_state_t;

  localparam logic [1:0] BUTTON_DATA_ADDR = 2'd0;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/qbert_debounce.sv
// Sample-driven debouncer: the level changes only after DEBOUNCE_N consecutive
// samples disagree with it, and each change emits a registered one-cycle pulse.
module qbert_debounce
  import qbert_poll_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_valid,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_N);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_N - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_valid) begin
        if (raw == level) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          // This sample is the DEBOUNCE_N-th disagreeing one in a row.
          level <= raw;
          cnt   <= '0;
          rise  <= raw;
          fall  <= ~raw;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/qbert_button_poller.sv
// Avalon-MM read initiator that polls the button PIO on a fixed tick, debounces
// bit 0 and hands the game logic a stable level plus press/release pulses.
module qbert_button_poller
  import qbert_poll_pkg::*;
#(
  parameter int POLL_DIV   = 50000,
  parameter int READ_WAIT  = 2,
  parameter int DEBOUNCE_N = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        button_level,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic        busy
);

  localparam int TW = cnt_width(POLL_DIV - 1);
  localparam int WW = cnt_width(READ_WAIT - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(POLL_DIV - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(READ_WAIT - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_next;
  poll_state_t   state;
  poll_state_t   state_next;
  logic          raw;
  logic          unused_readdata;

  // Free-running poll timebase, independent of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      IDLE: begin
        if (tick && enable) state_next = ISSUE;
      end
      ISSUE: begin
        wait_next  = WAIT_LOAD;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_next = SAMPLE;
        else                wait_next  = wait_cnt - WW'(1);
      end
      SAMPLE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign avm_read    = (state == ISSUE);
  assign avm_address = (state == ISSUE) ? BUTTON_DATA_ADDR : 2'd0;
  assign busy        = (state != IDLE);

  // Normalise to 1 = pressed before debouncing; upper data bits carry nothing.
  assign raw             = avm_readdata[0] ^ (ACTIVE_LOW != 0);
  assign unused_readdata = ^avm_readdata[31:1];

  qbert_debounce #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(state == SAMPLE),
    .raw         (raw),
    .level       (button_level),
    .rise        (press_pulse),
    .fall        (release_pulse)
  );

endmodule

// File: tb/tb_qbert_button_poller.sv
// Directed bench for qbert_button_poller with a registered PIO slave model and a
// cycle-indexed behavioural model of the poll schedule and debounce rule.
module tb_qbert_button_poller;

  localparam int POLL_DIV   = 8;
  localparam int READ_WAIT  = 2;
  localparam int DEBOUNCE_N = 3;
  localparam int ACTIVE_LOW = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        pin = 1'b1;
  logic [31:0] slave_data = 32'd1;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        button_level;
  logic        press_pulse;
  logic        release_pulse;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cyc is the number of clock edges since reset release.
  int cyc = 0;
  int m_issue = -100;
  int m_run = 0;
  bit m_level = 0, m_rise = 0, m_fall = 0, e_read = 0, e_busy = 0;
  bit raw_s, busy_now;

  // Events observed on the DUT, indexed by model cycle.
  int n_read = 0, n_press = 0, n_release = 0;
  int first_read = -1, last_read = -1, last_press = -1, last_release = -1;
  int rd0;

  always #5 clk = ~clk;

  // PIO slave: readdata registered every clock, bit 0 = pin.
  always_ff @(posedge clk) slave_data <= {31'd0, pin};

  qbert_button_poller #(
    .POLL_DIV  (POLL_DIV),
    .READ_WAIT (READ_WAIT),
    .DEBOUNCE_N(DEBOUNCE_N),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (slave_data),
    .button_level (button_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a read is issued the cycle after every tick (cycle % POLL_DIV
  // == POLL_DIV-1) seen with enable high, the transaction spans READ_WAIT+2 cycles,
  // the last of which samples slave data; the level flips after DEBOUNCE_N
  // consecutive samples that disagree with it.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; m_issue = -100; m_run = 0;
      m_level = 0; m_rise = 0; m_fall = 0; e_read = 0; e_busy = 0;
    end else begin
      busy_now = (cyc >= m_issue) && (cyc <= m_issue + READ_WAIT + 1);
      m_rise = 0;
      m_fall = 0;
      if (cyc == m_issue + READ_WAIT + 1) begin
        raw_s = slave_data[0] ^ ACTIVE_LOW[0];
        if (raw_s == m_level) m_run = 0;
        else begin
          m_run++;
          if (m_run == DEBOUNCE_N) begin
            m_level = raw_s; m_run = 0; m_rise = raw_s; m_fall = !raw_s;
          end
        end
      end
      if ((cyc % POLL_DIV == POLL_DIV - 1) && busy_now) begin
        n_fail++;
        $display("FAIL tick_while_busy: tick at cycle %0d during transaction", cyc);
      end
      if ((cyc % POLL_DIV == POLL_DIV - 1) && enable && !busy_now) m_issue = cyc + 1;
      cyc++;
      e_read = (cyc == m_issue);
      e_busy = (cyc >= m_issue) && (cyc <= m_issue + READ_WAIT + 1);
    end
  end

  // Per-cycle compare, sampled on the inactive edge.
  always @(negedge clk) begin
    check("avm_read", avm_read, e_read);
    check("avm_address", avm_address, 0);
    check("busy", busy, e_busy);
    check("button_level", button_level, m_level);
    check("press_pulse", press_pulse, m_rise);
    check("release_pulse", release_pulse, m_fall);
    if (reset_n) begin
      if (avm_read) begin
        n_read++; last_read = cyc;
        if (first_read < 0) first_read = cyc;
      end
      if (press_pulse)   begin n_press++;   last_press = cyc;   end
      if (release_pulse) begin n_release++; last_release = cyc; end
    end
  end

  initial begin
    // Reset / idle polling with the pin released.
    repeat (3) @(negedge clk);
    check("rst_read", avm_read, 0);
    check("rst_busy", busy, 0);
    check("rst_level", button_level, 0);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_reads", n_read, 12);
    check("first_read_cycle", first_read, 8);
    check("idle_press", n_press, 0);
    check("idle_release", n_release, 0);

    // Press: samples at 107/115/123, level rises the cycle after the third.
    pin = 1'b0;
    repeat (30) @(negedge clk);
    check("press_cycle", last_press, 124);
    check("press_count", n_press, 1);
    check("press_level", button_level, 1);

    // Release from pressed.
    pin = 1'b1;
    repeat (30) @(negedge clk);
    check("release_cycle", last_release, 148);
    check("release_count", n_release, 1);
    check("release_no_press", n_press, 1);
    check("release_level", button_level, 0);

    // Bounce 0,1,0,1 across polls, then hold released.
    pin = 1'b0; repeat (8) @(negedge clk);
    pin = 1'b1; repeat (8) @(negedge clk);
    pin = 1'b0; repeat (8) @(negedge clk);
    pin = 1'b1; repeat (16) @(negedge clk);
    check("bounce_press", n_press, 1);
    check("bounce_level", button_level, 0);
    pin = 1'b0;
    repeat (32) @(negedge clk);
    check("bounce_hold_cycle", last_press, 220);
    check("bounce_hold_count", n_press, 2);

    // Disable during WAIT: the in-flight sample still counts toward release.
    pin = 1'b1;
    @(negedge clk);
    check("dis_busy", busy, 1);
    enable = 1'b0;
    rd0 = n_read;
    repeat (50) @(negedge clk);
    check("dis_no_read", n_read, rd0);
    check("dis_read_total", n_read, 29);
    enable = 1'b1;
    repeat (18) @(negedge clk);
    check("reen_reads", n_read, 31);
    check("reen_last_read", last_read, 296);
    check("reen_release_cycle", last_release, 300);
    check("reen_release_count", n_release, 2);

    // Async reset mid-WAIT with two agreeing samples already counted.
    pin = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_read", avm_read, 0);
    check("arst_pulses", {press_pulse, release_pulse}, 0);
    check("arst_level", button_level, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_press_cycle", last_press, 28);
    check("post_rst_press_count", n_press, 3);
    check("post_rst_level", button_level, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qbert_button_poller.md
Name: qbert_button_poller

Overview:
- Avalon-MM read initiator for the single-bit button PIO slave. That slave registers `readdata` every clock, with bit 0 holding the raw pin and bits 31:1 reading 0.
- Periodically reads address 0, debounces bit 0, and publishes a stable button level plus one-cycle press/release pulses to Q*bert game logic.
- Sits between the PIO slave and game FSM; replaces software polling on the NIOS.

Parameters:
- POLL_DIV, 50000, clk cycles between read issues (1 ms at 50 MHz); legal range ≥ READ_WAIT+3.
- READ_WAIT, 2, cycles between read issue and `readdata` sample; covers the slave's registered read; range ≥1.
- DEBOUNCE_N, 4, consecutive agreeing samples needed to change the stable level; range ≥1.
- ACTIVE_LOW, 1, 1 = raw bit 0 means pressed when 0 (inverted before debounce).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- enable  in  1  polling enable
- avm_address  out  2  read address, always 0 during a read, 0 otherwise
- avm_read  out  1  read strobe, one cycle per poll
- avm_readdata  in  32  slave read data; only bit 0 used
- button_level  out  1  debounced level, 1 = pressed
- press_pulse  out  1  one-cycle pulse on 0→1 of `button_level`
- release_pulse  out  1  one-cycle pulse on 1→0 of `button_level`
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset is asserted, all registers are cleared:
  - `button_level`, `press_pulse`, `release_pulse`, `avm_read`, `busy` = 0; `avm_address` = 0.
  - Tick counter, debounce counter and wait counter = 0; FSM in IDLE.
  - Reset asserted mid-transaction aborts it immediately with no pulse.
- Tick counter: free-running, 0..POLL_DIV-1, wraps to 0. `tick` = (count == POLL_DIV-1). It runs regardless of `enable`.
- FSM (one-hot or enum):
  - IDLE: if `tick` && `enable`, go to ISSUE; else stay.
  - ISSUE: one cycle. `avm_read` = 1, `avm_address` = 0. Load wait counter with READ_WAIT-1. Go to WAIT.
  - WAIT: decrement the wait counter. When it is 0, go to SAMPLE.
  - SAMPLE: one cycle. Capture `raw = avm_readdata[0] ^ ACTIVE_LOW`. Feed the debouncer. Go to IDLE.
- Timing: ISSUE is exactly 1 cycle and WAIT is exactly READ_WAIT cycles. `readdata` is sampled READ_WAIT+1 edges after the ISSUE edge, so ISSUE→SAMPLE is READ_WAIT+1 cycles.
- `busy` = 1 in ISSUE/WAIT/SAMPLE.
- Ticks are never dropped when POLL_DIV ≥ READ_WAIT+3. A tick arriving while busy is ignored; this is unreachable within legal parameters, and the bench asserts on it.
- Disable: `enable` falling during a transaction lets it complete, including the debounce update; no further ISSUE follows. `enable` rising resumes at the next tick. Debounce state is retained across disable.
- Debouncer, updated only in SAMPLE:
  - If `raw == button_level`, clear the counter.
  - Otherwise increment the counter. When the incremented value equals DEBOUNCE_N:
    - toggle `button_level`;
    - clear the counter;
    - assert `press_pulse` (new level 1) or `release_pulse` (new level 0) on the following cycle, for exactly 1 cycle.
  - Counter width is clog2(DEBOUNCE_N+1). It never exceeds DEBOUNCE_N.
  - DEBOUNCE_N = 1 means the level follows every sample.
- `press_pulse` and `release_pulse` are never both high. Pulses are registered, so they are glitch-free.
- `avm_readdata[31:1]` is ignored.

Decomposition:
- Package `qbert_poll_pkg` holds:
  - state enum {IDLE, ISSUE, WAIT, SAMPLE};
  - address constant BUTTON_DATA_ADDR = 2'd0;
  - a clog2-based width function for the counters.
- One sub-module: `qbert_debounce` (inputs clk, reset_n, sample_valid, raw; outputs level, rise, fall; parameter DEBOUNCE_N).
- The top module holds the tick counter, FSM and Avalon outputs.

Test Plan:
Bench uses POLL_DIV=8, READ_WAIT=2, DEBOUNCE_N=3, ACTIVE_LOW=1, and a slave model with registered `readdata`.
- Reset/idle: pin held 1, `enable` = 1 for 100 cycles → `avm_read` pulses every 8 cycles, `avm_address` = 0, `button_level` = 0, no pulses.
- Press: pin → 0 → `button_level` rises after the 3rd sample seeing 0 (≤ 3×8 + 4 cycles after the change). `press_pulse` is high exactly 1 cycle, the cycle after that SAMPLE.
- Bounce: pin toggles 0,1,0,1 across successive polls, then holds 1 → `button_level` stays 0 and no pulse fires. Then a hold at 0 for 3 polls → exactly one `press_pulse`.
- Release: from pressed, pin → 1 for 3 polls → `button_level` = 0 and `release_pulse` for 1 cycle. `press_pulse` stays 0 throughout.
- Disable: drop `enable` during WAIT → SAMPLE still occurs, then no `avm_read` for 50 cycles. Re-enable → the next `avm_read` coincides with the cycle after a tick.
- Async reset mid-WAIT with the debounce counter at 2: assert reset_n = 0 between edges → all outputs 0 immediately. After release, 3 fresh samples are needed before any press is reported.
